fmi_pingpong_ctrl: RTL
======================

# fmi_pingpong_ctrl

Double-buffer (ping-pong) controller for the input feature-map RAM of the accelerator. The RAM holds two tile banks of `N_ELEM` pixels each. The DMA fills one bank while the compute core reads the other. The block tracks per-bank state, generates physical RAM addresses, and exposes ready/valid handshakes to both sides, so that loading the next tile overlaps processing of the current one.

## Interface
Parameters:
- `N_ELEM`, default `FMI_N_ELEM` (Tix*Tiy*Tif): pixels per tile bank.
- `PX_W`, default 16: pixel width.
- `EA_W`, default `$clog2(N_ELEM)`: in-bank address width.
- `RA_W`, default `$clog2(2*N_ELEM)`: physical RAM address width.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `dma_wr_en` in 1: DMA pixel write strobe.
- `dma_wr_data` in PX_W: DMA pixel.
- `dma_ready` out 1: a bank is accepting writes.
- `cmp_tile_valid` out 1: a complete tile is waiting in the read bank.
- `cmp_start` in 1: pulse; compute claims the valid tile.
- `cmp_rd_addr` in EA_W: in-bank read address.
- `cmp_release` in 1: pulse; compute has finished with the claimed tile.
- `ram_we` out 1: RAM write enable.
- `ram_waddr` out RA_W: RAM write address.
- `ram_wdata` out PX_W: RAM write data.
- `ram_raddr` out RA_W: RAM read address.
- `wr_bank`, `rd_bank` out 1 each: current write bank and current read bank.
- `ovf_err` out 1: sticky; a write was attempted while `dma_ready`=0.

## Operation
- Each bank has a 2-bit state: EMPTY(0), FILLING(1), FULL(2), READING(3).
- Pointers:
  - `wb` = `wr_bank`: bank that accepts DMA writes.
  - `rb` = `rd_bank`: bank offered to compute.
  - `wcnt`: EA_W-bit write counter within the current bank.
- Write path:
  - `dma_ready` = state[wb] ∈ {EMPTY, FILLING}.
  - An accepted write (`dma_wr_en` && `dma_ready`) stores the pixel at physical address `wb*N_ELEM + wcnt`.
  - If state[wb] was EMPTY, it becomes FILLING. `wcnt` increments.
  - When the accepted write has `wcnt` == N_ELEM-1:
    - state[wb] becomes FULL;
    - `wcnt` returns to 0;
    - `wb` toggles.
- Read path:
  - `cmp_tile_valid` = state[rb] == FULL.
  - `cmp_start` while valid sets state[rb] to READING. `cmp_start` while not valid is ignored.
  - `cmp_release` while state[rb] == READING sets it to EMPTY and toggles `rb`. `cmp_release` in any other state is ignored.
  - `ram_raddr` = `rb*N_ELEM + cmp_rd_addr`. This is combinational; `cmp_rd_addr` ≥ N_ELEM is undefined usage and is not checked.
- Simultaneous events:
  - A completing write and a release on the other bank in the same cycle are both applied.
  - A release on bank b and the first write into bank b can never coincide, because the bank states are exclusive.
  - `cmp_start` and the FULL transition of bank rb in the same cycle: the start is ignored, because valid is evaluated on the current state.
- Overflow: `dma_wr_en` with `dma_ready`=0 drops the pixel. No address or counter changes. `ovf_err` sets and stays set until `rst`.
- Reset: synchronous.
  - All banks EMPTY; `wb`=`rb`=0; `wcnt`=0.
  - `ram_we`=0, `ram_waddr`=0, `ram_wdata`=0, `ovf_err`=0.
  - Therefore `dma_ready`=1, `cmp_tile_valid`=0, `ram_raddr`=`cmp_rd_addr`.
  - Reset mid-fill or mid-read discards all tile state; a write registered in the reset cycle is not issued.

## Timing
- Write latency is 1 cycle. `ram_we`/`ram_waddr`/`ram_wdata` are registered copies of the accepted write and assert the cycle after `dma_wr_en`.
- Read address has 0 cycles of latency; RAM read latency belongs to the RAM.
- `dma_ready` and `cmp_tile_valid` reflect registered state. Both update the cycle after the causing event. Examples:
  - The last write of a tile sets valid on the next cycle if that bank is `rb`.
  - A release makes `dma_ready` rise on the next cycle if the DMA was stalled on that bank.
- Sustained throughput is one pixel per cycle on both sides.
- Fill and drain overlap fully when the read time per tile is ≥ N_ELEM cycles.

## Test plan
Use `N_ELEM`=8 for all scenarios.
- **Reset check:** assert `rst` 2 cycles, then check outputs → `dma_ready`=1, `cmp_tile_valid`=0, `wr_bank`=`rd_bank`=0, `ram_we`=0, `ovf_err`=0.
- **Single fill:** write data 0..7 on consecutive cycles → `ram_we` pulses with `ram_waddr` 0..7 one cycle later; `cmp_tile_valid`=1 the cycle after the 8th write; `wr_bank`=1.
- **Ping-pong overlap:** after the first fill, `cmp_start`, then write 8 more pixels while reading addresses 0..7 → writes land at 8..15, `ram_raddr`=0..7. After `cmp_release`: `rd_bank`=1, `cmp_tile_valid`=1 next cycle, and bank 0 accepts the next fill.
- **Overflow:** fill both banks (16 writes) without a start, then write once more → `dma_ready`=0, no `ram_we`, `ovf_err`=1 and stays 1. After start+release, `dma_ready`=1 again while `ovf_err` remains 1.
- **Illegal handshakes:** `cmp_start` and `cmp_release` while bank 0 is EMPTY → no state change, `rd_bank`=0.
- **Reset mid-operation:** assert `rst` after 5 writes into bank 0 → on the next cycle `wcnt`=0 and no FULL bank exists. A subsequent fill of 8 pixels starts again at `ram_waddr`=0.

Source files
------------

// File: rtl/fmi_pingpong_ctrl.sv
// Ping-pong controller for the input feature-map RAM: the DMA fills one tile bank
// while compute reads the other, with per-bank state and physical address generation.
`ifndef FMI_N_ELEM
`define FMI_N_ELEM 8
`endif

module fmi_pingpong_ctrl #(
   parameter int N_ELEM = `FMI_N_ELEM,
   parameter int PX_W   = 16,
   parameter int EA_W   = $clog2(N_ELEM),
   parameter int RA_W   = $clog2(2*N_ELEM)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            dma_wr_en,
   input  logic [PX_W-1:0] dma_wr_data,
   output logic            dma_ready,
   output logic            cmp_tile_valid,
   input  logic            cmp_start,
   input  logic [EA_W-1:0] cmp_rd_addr,
   input  logic            cmp_release,
   output logic            ram_we,
   output logic [RA_W-1:0] ram_waddr,
   output logic [PX_W-1:0] ram_wdata,
   output logic [RA_W-1:0] ram_raddr,
   output logic            wr_bank,
   output logic            rd_bank,
   output logic            ovf_err
);

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2,
      READING = 2'd3
   } bank_state_t;

   bank_state_t         bank_state_reg [2];
   bank_state_t         bank_state_next [2];
   logic                wb_reg, wb_next;
   logic                rb_reg, rb_next;
   logic [EA_W-1:0]     wcnt_reg, wcnt_next;
   logic                ram_we_reg, ram_we_next;
   logic [RA_W-1:0]     ram_waddr_reg, ram_waddr_next;
   logic [PX_W-1:0]     ram_wdata_reg, ram_wdata_next;
   logic                ovf_reg, ovf_next;
   logic                wr_accept;
   logic [RA_W-1:0]     wr_base, rd_base;

   assign wr_base        = wb_reg ? RA_W'(N_ELEM) : '0;
   assign rd_base        = rb_reg ? RA_W'(N_ELEM) : '0;
   assign dma_ready      = (bank_state_reg[wb_reg] == EMPTY) || (bank_state_reg[wb_reg] == FILLING);
   assign cmp_tile_valid = (bank_state_reg[rb_reg] == FULL);
   assign wr_accept      = dma_wr_en && dma_ready;
   assign ram_raddr      = rd_base + RA_W'(cmp_rd_addr);

   assign ram_we    = ram_we_reg;
   assign ram_waddr = ram_waddr_reg;
   assign ram_wdata = ram_wdata_reg;
   assign wr_bank   = wb_reg;
   assign rd_bank   = rb_reg;
   assign ovf_err   = ovf_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         bank_state_reg[0] <= EMPTY;
         bank_state_reg[1] <= EMPTY;
         wb_reg            <= 1'b0;
         rb_reg            <= 1'b0;
         wcnt_reg          <= '0;
         ram_we_reg        <= 1'b0;
         ram_waddr_reg     <= '0;
         ram_wdata_reg     <= '0;
         ovf_reg           <= 1'b0;
      end else begin
         bank_state_reg[0] <= bank_state_next[0];
         bank_state_reg[1] <= bank_state_next[1];
         wb_reg            <= wb_next;
         rb_reg            <= rb_next;
         wcnt_reg          <= wcnt_next;
         ram_we_reg        <= ram_we_next;
         ram_waddr_reg     <= ram_waddr_next;
         ram_wdata_reg     <= ram_wdata_next;
         ovf_reg           <= ovf_next;
      end
   end

   // Write and read updates never touch the same bank in one cycle: the write side only
   // acts on EMPTY/FILLING banks, the read side only on FULL/READING ones.
   always_comb begin
      bank_state_next[0] = bank_state_reg[0];
      bank_state_next[1] = bank_state_reg[1];
      wb_next            = wb_reg;
      rb_next            = rb_reg;
      wcnt_next          = wcnt_reg;
      ram_we_next        = 1'b0;
      ram_waddr_next     = ram_waddr_reg;
      ram_wdata_next     = ram_wdata_reg;
      ovf_next           = ovf_reg | (dma_wr_en & ~dma_ready);

      if (wr_accept) begin
         ram_we_next    = 1'b1;
         ram_waddr_next = wr_base + RA_W'(wcnt_reg);
         ram_wdata_next = dma_wr_data;
         if (wcnt_reg == EA_W'(N_ELEM - 1)) begin
            bank_state_next[wb_reg] = FULL;
            wcnt_next               = '0;
            wb_next                 = ~wb_reg;
         end else begin
            bank_state_next[wb_reg] = FILLING;
            wcnt_next               = wcnt_reg + EA_W'(1);
         end
      end

      // Start is judged on the registered state, so a bank turning FULL this cycle is not claimable yet.
      if (cmp_start && cmp_tile_valid) begin
         bank_state_next[rb_reg] = READING;
      end else if (cmp_release && (bank_state_reg[rb_reg] == READING)) begin
         bank_state_next[rb_reg] = EMPTY;
         rb_next                 = ~rb_reg;
      end
   end

endmodule
